// File: rtl/rtc_slew.sv
// rtl/rtc_slew.sv - seconds/nanoseconds time-of-day counter with delta-sigma period fraction and slewed offset
module rtc_slew #(
    parameter int              SEC_W      = 48,
    parameter int              NS_W       = 30,
    parameter int              FRAC_W     = 8,
    parameter int              PER_FRAC_W = 32,
    parameter int              ADJ_CNT_W  = 32,
    parameter longint unsigned NS_MOD     = 1000000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   time_ld,
    input  logic [NS_W+FRAC_W-1:0] time_ns_in,
    input  logic [SEC_W-1:0]       time_sec_in,
    input  logic                   period_ld,
    input  logic [8+PER_FRAC_W-1:0] period_in,
    input  logic                   adj_ld,
    input  logic [ADJ_CNT_W-1:0]   adj_cycles,
    input  logic [8+PER_FRAC_W-1:0] period_adj,
    input  logic                   cap_req,
    output logic [NS_W+FRAC_W-1:0] time_ns,
    output logic [SEC_W-1:0]       time_sec,
    output logic                   pps,
    output logic                   adj_busy,
    output logic                   adj_done,
    output logic [NS_W+FRAC_W-1:0] cap_ns,
    output logic [SEC_W-1:0]       cap_sec,
    output logic                   cap_valid
);
    localparam int ACC_W  = NS_W + FRAC_W;
    localparam int PER_W  = 8 + PER_FRAC_W;
    localparam int EFF_W  = PER_W + 1;
    localparam int RES_W  = PER_FRAC_W - FRAC_W;
    localparam int STEP_W = EFF_W - RES_W;
    localparam logic [ACC_W:0] NS_LIM = (ACC_W+1)'(NS_MOD) << FRAC_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SLEW = 1'b1;

    logic [PER_W-1:0]     period_fix_q, period_fix_d;
    logic [PER_W-1:0]     adj_val_q, adj_val_d;
    logic [ADJ_CNT_W-1:0] adj_cnt_q, adj_cnt_d;
    logic [0:0]           state_q, state_d;
    logic                 adj_done_q, adj_done_d;
    logic [RES_W-1:0]     resid_q, resid_d;
    logic [ACC_W-1:0]     ns_acc_q, ns_acc_d;
    logic [SEC_W-1:0]     sec_acc_q, sec_acc_d;
    logic                 pps_q, pps_d;
    logic [ACC_W-1:0]     cap_ns_q, cap_ns_d;
    logic [SEC_W-1:0]     cap_sec_q, cap_sec_d;
    logic                 cap_valid_q, cap_valid_d;

    logic [EFF_W-1:0]  adj_ext;
    logic [EFF_W-1:0]  eff_raw;
    logic [PER_W-1:0]  period_eff;
    logic [EFF_W-1:0]  sum;
    logic [STEP_W-1:0] step;
    logic [ACC_W:0]    nxt;

    // Top bit of the 9+PER_FRAC_W sum is the sign; a negative period freezes time.
    always_comb begin
        adj_ext    = (state_q == S_SLEW) ? {adj_val_q[PER_W-1], adj_val_q} : '0;
        eff_raw    = {1'b0, period_fix_q} + adj_ext;
        period_eff = eff_raw[EFF_W-1] ? '0 : eff_raw[PER_W-1:0];
        sum        = {1'b0, period_eff} + {{(EFF_W-RES_W){1'b0}}, resid_q};
        step       = sum[EFF_W-1:RES_W];
        nxt        = {1'b0, ns_acc_q} + {{(ACC_W+1-STEP_W){1'b0}}, step};
    end

    always_comb begin
        resid_d     = sum[RES_W-1:0];
        ns_acc_d    = nxt[ACC_W-1:0];
        sec_acc_d   = sec_acc_q;
        pps_d       = 1'b0;
        if (time_ld) begin
            ns_acc_d  = ({1'b0, time_ns_in} >= NS_LIM) ? '0 : time_ns_in;
            sec_acc_d = time_sec_in;
        end else if (nxt >= NS_LIM) begin
            ns_acc_d  = ACC_W'(nxt - NS_LIM);
            sec_acc_d = sec_acc_q + SEC_W'(1);
            pps_d     = 1'b1;
        end

        period_fix_d = period_ld ? period_in : period_fix_q;

        adj_val_d  = adj_val_q;
        adj_cnt_d  = adj_cnt_q;
        state_d    = state_q;
        adj_done_d = 1'b0;
        if (adj_ld) begin
            if (adj_cycles != '0) begin
                adj_val_d = period_adj;
                adj_cnt_d = adj_cycles;
                state_d   = S_SLEW;
            end else begin
                adj_cnt_d = '0;
                state_d   = S_IDLE;
            end
        end else if (state_q == S_SLEW) begin
            adj_cnt_d = adj_cnt_q - ADJ_CNT_W'(1);
            if (adj_cnt_q == ADJ_CNT_W'(1)) begin
                state_d    = S_IDLE;
                adj_done_d = 1'b1;
            end
        end

        cap_ns_d    = cap_req ? ns_acc_q : cap_ns_q;
        cap_sec_d   = cap_req ? sec_acc_q : cap_sec_q;
        cap_valid_d = cap_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_fix_q <= '0;
            adj_val_q    <= '0;
            adj_cnt_q    <= '0;
            state_q      <= S_IDLE;
            adj_done_q   <= 1'b0;
            resid_q      <= '0;
            ns_acc_q     <= '0;
            sec_acc_q    <= '0;
            pps_q        <= 1'b0;
            cap_ns_q     <= '0;
            cap_sec_q    <= '0;
            cap_valid_q  <= 1'b0;
        end else begin
            period_fix_q <= period_fix_d;
            adj_val_q    <= adj_val_d;
            adj_cnt_q    <= adj_cnt_d;
            state_q      <= state_d;
            adj_done_q   <= adj_done_d;
            resid_q      <= resid_d;
            ns_acc_q     <= ns_acc_d;
            sec_acc_q    <= sec_acc_d;
            pps_q        <= pps_d;
            cap_ns_q     <= cap_ns_d;
            cap_sec_q    <= cap_sec_d;
            cap_valid_q  <= cap_valid_d;
        end
    end

    assign time_ns   = ns_acc_q;
    assign time_sec  = sec_acc_q;
    assign pps       = pps_q;
    assign adj_busy  = (state_q == S_SLEW);
    assign adj_done  = adj_done_q;
    assign cap_ns    = cap_ns_q;
    assign cap_sec   = cap_sec_q;
    assign cap_valid = cap_valid_q;
endmodule

// File: doc/rtc_slew.md
# rtc_slew

Parametrised real-time clock: a seconds/nanoseconds time-of-day accumulator for the timestamping path. It advances by a programmable per-cycle period, and a delta-sigma stage carries the period fraction bits that fall below the accumulator resolution. Software can apply a signed period offset slewed over N cycles with busy/done status. The block also emits a one-cycle PPS pulse at each second rollover and provides an atomic time capture port for timestampers and the register interface.

## Interface
- SEC_W, 48, seconds width
- NS_W, 30, integer-nanosecond width
- FRAC_W, 8, accumulator ns-fraction bits (FRAC_W < PER_FRAC_W)
- PER_FRAC_W, 32, period ns-fraction bits
- ADJ_CNT_W, 32, slew cycle-count width
- NS_MOD, 1000000000, ns rollover value (integer ns)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- time_ld  in  1  load time of day
- time_ns_in  in  NS_W+FRAC_W  ns value to load; upper NS_W bits = ns, lower FRAC_W = fraction
- time_sec_in  in  SEC_W  seconds value to load
- period_ld  in  1  load nominal period
- period_in  in  8+PER_FRAC_W  unsigned period; upper 8 bits = ns, lower PER_FRAC_W = fraction
- adj_ld  in  1  start slewed adjustment
- adj_cycles  in  ADJ_CNT_W  number of cycles the offset is applied
- period_adj  in  8+PER_FRAC_W  signed (two's complement) per-cycle period offset
- cap_req  in  1  capture strobe
- time_ns  out  NS_W+FRAC_W  current ns and fraction
- time_sec  out  SEC_W  current seconds
- pps  out  1  one-cycle pulse on second rollover
- adj_busy  out  1  offset being applied this cycle
- adj_done  out  1  one-cycle pulse, slew completed
- cap_ns  out  NS_W+FRAC_W  captured ns
- cap_sec  out  SEC_W  captured seconds
- cap_valid  out  1  one-cycle pulse, capture registers updated

## Operation
- State: period_fix, adj_val, adj_cnt, adj_busy, resid (PER_FRAC_W−FRAC_W bits), ns_acc, sec_acc.
- Reset value of every register and output is 0.
- Effective period: period_eff = period_fix + (adj_busy ? sign-extended adj_val : 0), computed at 9+PER_FRAC_W bits. A negative result saturates to 0.
- Delta-sigma stage:
  - sum = period_eff + resid.
  - step = sum >> (PER_FRAC_W−FRAC_W).
  - resid <= low (PER_FRAC_W−FRAC_W) bits of sum.
  - resid updates every cycle, including time_ld cycles.
- Accumulator:
  - nxt = ns_acc + step.
  - If nxt ≥ NS_MOD·2^FRAC_W: ns_acc <= nxt − NS_MOD·2^FRAC_W, sec_acc <= sec_acc+1 (wraps at 2^SEC_W), pps <= 1.
  - Otherwise ns_acc <= nxt, pps <= 0.
  - Seconds increment in the same cycle as the ns wrap (no lag cycle).
- time_ld has priority over the increment:
  - ns_acc <= time_ns_in, or 0 if time_ns_in ≥ NS_MOD·2^FRAC_W.
  - sec_acc <= time_sec_in.
  - pps <= 0.
- period_ld: period_fix <= period_in.
- Slew state machine, states IDLE and SLEW:
  - IDLE, adj_ld with adj_cycles≠0: adj_val <= period_adj, adj_cnt <= adj_cycles, go to SLEW (adj_busy=1).
  - SLEW: adj_cnt decrements each cycle. When it reaches 1 and is consumed, adj_busy <= 0, adj_done <= 1, go to IDLE.
  - adj_ld in SLEW restarts with the new values; no adj_done for the aborted slew.
  - adj_ld with adj_cycles=0 cancels: go to IDLE with no adj_done.
  - time_ld does not affect the slew.
- Capture: on cap_req, cap_ns/cap_sec <= time_ns/time_sec values present in that cycle (before that edge's update) and cap_valid <= 1. cap_req coincident with time_ld captures the pre-load value.

## Timing
- All outputs are registered.
- period_ld at edge k: new period used for the increment at edge k+1.
- adj_ld with N cycles at edge k: adj_busy is high for cycles k+1 .. k+N, so exactly N increments include the offset. adj_done is high in cycle k+N+1.
- time_ld at edge k: time outputs show the loaded value after edge k. The first increment happens at edge k+1.
- pps is high in the same cycle that time_sec shows the incremented value.
- cap_valid and cap_* are updated one edge after cap_req.
- Simultaneous period_ld and adj_ld are both honoured; period_eff at k+1 uses both new values.
- Asserting rst mid-slew or mid-count returns everything to 0 immediately.

## Test plan
- Default parameters, period_in=0x08_00000000, run 125,000,000 cycles from time 0 -> time_sec=1, time_ns=0, single pps pulse in that cycle.
- period_in=0x08_00800000 (8 + 1/512 ns) -> ns fraction advances by 8·256+0 per cycle, with +1 LSB on every second cycle (resid carry); after 512 cycles the fraction total is exactly 4097 ns.
- time_ld with ns=999,999,992·256, sec=5, period 8 ns -> next cycle time_sec=6, time_ns=0, pps=1.
- adj_ld with adj_cycles=4, period_adj=+1 ns, period 8 ns -> four increments of 9 ns, adj_busy high exactly 4 cycles, adj_done pulse in cycle 5, net offset +4 ns.
- adj_ld with adj_cycles=10, then adj_ld with adj_cycles=0 after 3 cycles -> offset +3 ns only, no adj_done; period_adj=−9 ns saturates the step to 0 (time frozen).
- cap_req coincident with time_ld -> cap_* hold the pre-load time, cap_valid one cycle; time_ns_in=NS_MOD·256 -> loads 0.
